// File: rtl/sw_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : sw_param_if
//  Purpose  : Bundles the flit buses and flow-control flags of the
//             sw_param packet switch.
//  Signals  : i_flit  - N*W packed input flits (port k at [k*W+W-1:k*W])
//             i_full  - per-input FIFO full flag
//             i_ovf   - per-input sticky overflow flag
//             o_flit  - N*W packed registered output flits
//             o_ready - per-output downstream accept
//  Modports : master - link side (drives flits and ready)
//             slave  - switch side
//  Revision : 1.0 - initial release
// ============================================================================
interface sw_param_if #(
   parameter int N = 4,
   parameter int W = 10
);
   logic [N*W-1:0] i_flit;
   logic [N-1:0]   i_full;
   logic [N-1:0]   i_ovf;
   logic [N*W-1:0] o_flit;
   logic [N-1:0]   o_ready;

   modport master (
      output i_flit,
      output o_ready,
      input  i_full,
      input  i_ovf,
      input  o_flit
   );

   modport slave (
      input  i_flit,
      input  o_ready,
      output i_full,
      output i_ovf,
      output o_flit
   );
endinterface
`default_nettype wire

// File: rtl/sw_param.sv
`default_nettype none
// ============================================================================
//  Module   : sw_param
//  Purpose  : N-port wormhole packet switch. Each input has a D-flit FIFO;
//             each output has a round-robin arbiter that locks onto the
//             winning input for the whole packet, and a registered output
//             stage that holds a flit until the downstream accepts it.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous reset, active low
//             bus - sw_param_if.slave (i_flit, i_full, i_ovf, o_flit, o_ready)
//  Revision : 1.0 - initial release
// ============================================================================
module sw_param #(
   parameter int N = 4,
   parameter int W = 10,
   parameter int D = 4
) (
   input  logic        clk,
   input  logic        rst,
   sw_param_if.slave   bus
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(D);

   localparam logic [1:0]    c_T_IDLE = 2'b00;
   localparam logic [1:0]    c_T_HEAD = 2'b01;
   localparam logic [1:0]    c_T_BODY = 2'b10;
   localparam logic [1:0]    c_T_TAIL = 2'b11;
   localparam logic [AW:0]   c_DEPTH  = (AW+1)'(D);
   localparam logic [SW:0]   c_NPORT  = (SW+1)'(N);

   // ---------------------------------------------------------------- state
   logic [W-1:0]  r_mem   [N][D];
   logic [AW-1:0] r_wp    [N];
   logic [AW-1:0] r_rp    [N];
   logic [AW:0]   r_cnt   [N];
   logic [N-1:0]  r_ovf;
   logic [N-1:0]  r_lock;
   logic [N-1:0]  r_cool;     // output just released a packet: hold off one grant
   logic [SW-1:0] r_owner [N];
   logic [SW-1:0] r_ptr   [N];
   logic [W-1:0]  r_of    [N];

   // ---------------------------------------------------------------- comb
   logic [W-1:0]  w_in    [N];
   logic [W-1:0]  w_front [N];
   logic [SW-1:0] w_dest  [N];
   logic [SW-1:0] w_src   [N];
   logic [N-1:0]  w_wr, w_nemp, w_full, w_owns, w_req, w_disc, w_pop;
   logic [N-1:0]  w_acc, w_xfer, w_grant, w_tail;
   logic          w_found;
   int            w_idx;
   logic [SW-1:0] w_sel;

   // Destinations beyond the last port wrap back modulo N.
   function automatic logic [SW-1:0] f_dest(input logic [SW-1:0] raw);
      logic [SW:0] d;
      d = {1'b0, raw};
      if (d >= c_NPORT) d = d - c_NPORT;
      return d[SW-1:0];
   endfunction

   for (genvar k = 0; k < N; k++) begin : g_port
      assign w_in[k]                = bus.i_flit[k*W +: W];
      assign bus.o_flit[k*W +: W]   = r_of[k];
   end

   assign bus.i_full = w_full;
   assign bus.i_ovf  = r_ovf;

   // FIFO status and per-input request classification
   always_comb begin
      w_wr   = '0;
      w_nemp = '0;
      w_full = '0;
      w_owns = '0;
      w_req  = '0;
      w_disc = '0;
      for (int k = 0; k < N; k++) begin
         w_front[k] = r_mem[k][r_rp[k]];
         w_dest[k]  = f_dest(w_front[k][SW-1:0]);
         w_nemp[k]  = (r_cnt[k] != '0);
         w_full[k]  = (r_cnt[k] == c_DEPTH);
         // full is judged before the edge, so a simultaneous pop does not help
         w_wr[k]    = (w_in[k][W-1:W-2] != c_T_IDLE) && !w_full[k];
         for (int j = 0; j < N; j++) begin
            if (r_lock[j] && (r_owner[j] == SW'(k))) w_owns[k] = 1'b1;
         end
         w_req[k]  = w_nemp[k] && (w_front[k][W-1:W-2] == c_T_HEAD) && !w_owns[k];
         // orphan body/tail with no path: drop it
         w_disc[k] = w_nemp[k] && !w_owns[k] &&
                     ((w_front[k][W-1:W-2] == c_T_BODY) ||
                      (w_front[k][W-1:W-2] == c_T_TAIL));
      end
   end

   // Per-output arbitration and transfer decision
   always_comb begin
      w_acc   = '0;
      w_xfer  = '0;
      w_grant = '0;
      w_tail  = '0;
      w_found = 1'b0;
      w_idx   = 0;
      w_sel   = '0;
      for (int j = 0; j < N; j++) begin
         w_src[j] = r_owner[j];
         w_acc[j] = (r_of[j][W-1:W-2] == c_T_IDLE) || bus.o_ready[j];
         if (r_lock[j]) begin
            // an empty owner FIFO just leaves a bubble; the lock stays
            w_xfer[j] = w_nemp[r_owner[j]] && w_acc[j];
         end else if (!r_cool[j]) begin
            w_found = 1'b0;
            for (int i = 1; i <= N; i++) begin
               w_idx = (int'(r_ptr[j]) + i) % N;
               w_sel = SW'(w_idx);
               if (!w_found && w_req[w_sel] && (w_dest[w_sel] == SW'(j))) begin
                  w_found  = 1'b1;
                  w_src[j] = w_sel;
               end
            end
            w_grant[j] = w_found && w_acc[j];
            w_xfer[j]  = w_grant[j];
         end
         w_tail[j] = w_xfer[j] && (w_front[w_src[j]][W-1:W-2] == c_T_TAIL);
      end
   end

   always_comb begin
      w_pop = w_disc;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (w_xfer[j] && (w_src[j] == SW'(k))) w_pop[k] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- FIFO storage
   always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (w_wr[k]) r_mem[k][r_wp[k]] <= w_in[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= '0;
         for (int k = 0; k < N; k++) begin
            r_wp[k]  <= '0;
            r_rp[k]  <= '0;
            r_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_wr[k])  r_wp[k] <= r_wp[k] + AW'(1);
            if (w_pop[k]) r_rp[k] <= r_rp[k] + AW'(1);
            case ({w_wr[k], w_pop[k]})
               2'b10:   r_cnt[k] <= r_cnt[k] + (AW+1)'(1);
               2'b01:   r_cnt[k] <= r_cnt[k] - (AW+1)'(1);
               default: r_cnt[k] <= r_cnt[k];
            endcase
            if ((w_in[k][W-1:W-2] != c_T_IDLE) && w_full[k]) r_ovf[k] <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs, locks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lock <= '0;
         r_cool <= '0;
         for (int j = 0; j < N; j++) begin
            r_of[j]    <= '0;
            r_owner[j] <= '0;
            r_ptr[j]   <= SW'(N-1);
         end
      end else begin
         r_cool <= w_tail;
         for (int j = 0; j < N; j++) begin
            if (w_xfer[j])             r_of[j] <= w_front[w_src[j]];
            else if (bus.o_ready[j])   r_of[j] <= '0;
            if (w_grant[j]) begin
               r_lock[j]  <= 1'b1;
               r_owner[j] <= w_src[j];
               r_ptr[j]   <= w_src[j];
            end else if (w_tail[j]) begin
               r_lock[j]  <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sw_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_param
//  Purpose  : Directed self-checking bench for sw_param (N=4, W=10, D=4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sw_param;

   localparam int N = 4;
   localparam int W = 10;
   localparam int D = 4;

   logic clk;
   logic rst;
   int   r_ncmp;
   int   r_nmis;

   sw_param_if #(.N(N), .W(W)) bus ();

   sw_param #(.N(N), .W(W), .D(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic [W-1:0] f);
      bus.i_flit[k*W +: W] = f;
   endtask

   function automatic logic [W-1:0] get_o(input int j);
      return bus.o_flit[j*W +: W];
   endfunction

   task automatic do_reset();
      rst         = 1'b0;
      bus.i_flit  = '0;
      bus.o_ready = '1;
      step();
      step();
      rst = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst         = 1'b0;
      bus.o_ready = '1;
      bus.i_flit  = '0;
      drive(0, 10'h102);
      step();
      r_ncmp++;
      if (bus.o_flit !== '0) begin
         r_nmis++; $display("FAIL reset o_flit: got %h expected 0", bus.o_flit);
      end
      r_ncmp++;
      if (bus.i_full !== '0) begin
         r_nmis++; $display("FAIL reset i_full: got %b expected 0", bus.i_full);
      end
      r_ncmp++;
      if (bus.i_ovf !== '0) begin
         r_nmis++; $display("FAIL reset i_ovf: got %b expected 0", bus.i_ovf);
      end
      bus.i_flit = '0;
      rst = 1'b1;
      step();
      step();
      r_ncmp++;
      if (bus.o_flit !== '0) begin
         r_nmis++; $display("FAIL reset held-flit o_flit: got %h expected 0", bus.o_flit);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single();
      logic [W-1:0] v_in  [6] = '{10'h102, 10'h2AA, 10'h355, 10'h000, 10'h000, 10'h000};
      logic [W-1:0] v_exp [6] = '{10'h000, 10'h102, 10'h2AA, 10'h355, 10'h000, 10'h000};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(0, v_in[c]);
         step();
         r_ncmp++;
         if (get_o(2) !== v_exp[c]) begin
            r_nmis++;
            $display("FAIL single o2 step %0d: got %h expected %h", c, get_o(2), v_exp[c]);
         end
         r_ncmp++;
         if ((get_o(0) | get_o(1) | get_o(3)) !== '0) begin
            r_nmis++;
            $display("FAIL single other outputs step %0d: got %h expected 0", c, bus.o_flit);
         end
      end
      r_ncmp++;
      if (bus.i_full !== '0) begin
         r_nmis++; $display("FAIL single i_full: got %b expected 0", bus.i_full);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_contention();
      logic [W-1:0] v_a [3] = '{10'h101, 10'h2A0, 10'h3A1};
      logic [W-1:0] v_b [3] = '{10'h101, 10'h2B0, 10'h3B1};
      logic [W-1:0] v_exp [9] = '{10'h000, 10'h101, 10'h2A0, 10'h3A1, 10'h000,
                                  10'h101, 10'h2B0, 10'h3B1, 10'h000};
      logic [W-1:0] v_c [2] = '{10'h101, 10'h3C1};
      logic [W-1:0] v_d [2] = '{10'h101, 10'h3D2};
      logic [W-1:0] v_exp2 [8] = '{10'h000, 10'h101, 10'h3D2, 10'h000,
                                   10'h101, 10'h3C1, 10'h000, 10'h000};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         drive(0, (c < 3) ? v_a[c] : 10'h000);
         drive(1, (c < 3) ? v_b[c] : 10'h000);
         step();
         r_ncmp++;
         if (get_o(1) !== v_exp[c]) begin
            r_nmis++;
            $display("FAIL contention o1 step %0d: got %h expected %h", c, get_o(1), v_exp[c]);
         end
      end
      // pointer of output 1 now rests on input 1, so input 2 beats input 1
      for (int c = 0; c < 8; c++) begin
         drive(1, (c < 2) ? v_c[c] : 10'h000);
         drive(2, (c < 2) ? v_d[c] : 10'h000);
         step();
         r_ncmp++;
         if (get_o(1) !== v_exp2[c]) begin
            r_nmis++;
            $display("FAIL contention-ptr o1 step %0d: got %h expected %h", c, get_o(1), v_exp2[c]);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_round_robin();
      logic [W-1:0] v_seen [$];
      logic [W-1:0] v_exp;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         for (int k = 0; k < N; k++) begin
            if (c < 4) drive(k, (c % 2 == 0) ? 10'h100 : (10'h300 | W'(k)));
            else       drive(k, 10'h000);
         end
         step();
         if (get_o(0) !== '0) v_seen.push_back(get_o(0));
      end
      r_ncmp++;
      if (v_seen.size() != 16) begin
         r_nmis++;
         $display("FAIL rr flit count: got %0d expected 16", v_seen.size());
      end
      for (int i = 0; i < 16 && i < v_seen.size(); i++) begin
         v_exp = (i % 2 == 0) ? 10'h100 : (10'h300 | W'((i / 2) % N));
         r_ncmp++;
         if (v_seen[i] !== v_exp) begin
            r_nmis++;
            $display("FAIL rr order flit %0d: got %h expected %h", i, v_seen[i], v_exp);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_backpressure();
      logic [W-1:0] v_in [6] = '{10'h103, 10'h201, 10'h202, 10'h203, 10'h204, 10'h205};
      logic [W-1:0] v_exp [6] = '{10'h201, 10'h202, 10'h203, 10'h204, 10'h3EE, 10'h000};
      do_reset();
      bus.o_ready = 4'b0111;
      for (int c = 0; c < 6; c++) begin
         drive(2, v_in[c]);
         step();
         if (c == 3) begin
            r_ncmp++;
            if (bus.i_full[2] !== 1'b0) begin
               r_nmis++; $display("FAIL bp full-early: got %b expected 0", bus.i_full[2]);
            end
         end
         if (c == 4) begin
            r_ncmp++;
            if (bus.i_full[2] !== 1'b1) begin
               r_nmis++; $display("FAIL bp full: got %b expected 1", bus.i_full[2]);
            end
            r_ncmp++;
            if (bus.i_ovf[2] !== 1'b0) begin
               r_nmis++; $display("FAIL bp ovf-early: got %b expected 0", bus.i_ovf[2]);
            end
         end
      end
      drive(2, 10'h000);
      r_ncmp++;
      if (bus.i_ovf !== 4'b0100) begin
         r_nmis++; $display("FAIL bp ovf: got %b expected 0100", bus.i_ovf);
      end
      step();
      step();
      r_ncmp++;
      if (get_o(3) !== 10'h103) begin
         r_nmis++; $display("FAIL bp hold: got %h expected 103", get_o(3));
      end
      bus.o_ready = '1;
      for (int c = 0; c < 6; c++) begin
         drive(2, (c == 1) ? 10'h3EE : 10'h000);
         step();
         r_ncmp++;
         if (get_o(3) !== v_exp[c]) begin
            r_nmis++;
            $display("FAIL bp drain step %0d: got %h expected %h", c, get_o(3), v_exp[c]);
         end
      end
      r_ncmp++;
      if (bus.i_ovf !== 4'b0100) begin
         r_nmis++; $display("FAIL bp ovf sticky: got %b expected 0100", bus.i_ovf);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_parallel();
      logic [W-1:0] v_a [3] = '{10'h103, 10'h2C0, 10'h3C1};
      logic [W-1:0] v_b [3] = '{10'h100, 10'h2D0, 10'h3D1};
      logic [W-1:0] v_ea [5] = '{10'h000, 10'h103, 10'h2C0, 10'h3C1, 10'h000};
      logic [W-1:0] v_eb [5] = '{10'h000, 10'h100, 10'h2D0, 10'h3D1, 10'h000};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(0, (c < 3) ? v_a[c] : 10'h000);
         drive(3, (c < 3) ? v_b[c] : 10'h000);
         step();
         r_ncmp++;
         if ((get_o(3) !== v_ea[c]) || (get_o(0) !== v_eb[c])) begin
            r_nmis++;
            $display("FAIL parallel step %0d: got o3=%h o0=%h expected o3=%h o0=%h",
                     c, get_o(3), get_o(0), v_ea[c], v_eb[c]);
         end
         r_ncmp++;
         if ((get_o(1) | get_o(2)) !== '0) begin
            r_nmis++;
            $display("FAIL parallel idle outputs step %0d: got %h expected 0", c, bus.o_flit);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid();
      logic [W-1:0] v_in [3] = '{10'h101, 10'h2A1, 10'h3A2};
      logic [W-1:0] v_exp [6] = '{10'h000, 10'h101, 10'h3B1, 10'h000, 10'h000, 10'h000};
      do_reset();
      bus.o_ready = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         drive(0, v_in[c]);
         step();
      end
      drive(0, 10'h000);
      r_ncmp++;
      if (get_o(1) !== 10'h101) begin
         r_nmis++; $display("FAIL rstmid pre: got %h expected 101", get_o(1));
      end
      #2;
      rst = 1'b0;
      #1;
      r_ncmp++;
      if (bus.o_flit !== '0) begin
         r_nmis++; $display("FAIL rstmid async o_flit: got %h expected 0", bus.o_flit);
      end
      step();
      step();
      rst = 1'b1;
      bus.o_ready = '1;
      for (int c = 0; c < 6; c++) begin
         drive(1, (c == 0) ? 10'h101 : ((c == 1) ? 10'h3B1 : 10'h000));
         step();
         r_ncmp++;
         if (get_o(1) !== v_exp[c]) begin
            r_nmis++;
            $display("FAIL rstmid after step %0d: got %h expected %h", c, get_o(1), v_exp[c]);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      r_ncmp      = 0;
      r_nmis      = 0;
      rst         = 1'b0;
      bus.i_flit  = '0;
      bus.o_ready = '1;
      test_reset();
      test_single();
      test_contention();
      test_round_robin();
      test_backpressure();
      test_parallel();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_ncmp, r_nmis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sw_param.md
Name: sw_param

Overview:
- Parametrised N-port wormhole packet switch; next generation of the fixed 4x4 switch.
- Per-input FIFO buffering, per-output round-robin arbitration with packet lock, registered crossbar outputs.
- Adds over the fixed switch: per-output backpressure, input full and overflow flags.
- Sits between router links; packets are streams of typed flits.

Parameters:
N, 4, number of input and output ports (2..8)
W, 10, flit width; bits [W-1:W-2] are the type, bits [W-3:0] are the payload
D, 4, input FIFO depth in flits (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
i_flit  in  N*W  input flits; port k occupies bits [k*W+W-1:k*W]
i_full  out  N  input k FIFO holds D flits
i_ovf  out  N  sticky: a flit arrived at input k while it was full
o_flit  out  N*W  output flits, same packing as i_flit
o_ready  in  N  downstream of output j accepts a flit this cycle

Behaviour:
- Flit types:
  - 00 idle: not a flit, never stored.
  - 01 head: destination = payload[$clog2(N)-1:0].
  - 10 body.
  - 11 tail.
  - A packet is head, zero or more body, tail; minimum length 2.
- Reset (rst low, asynchronous): all FIFOs empty; i_full=0; i_ovf=0; o_flit=0 (idle on all outputs); all locks clear; all RR pointers=N-1, so input 0 wins first.
- Input write:
  - Non-idle flit on i_flit[k] is written to FIFO k on the clock edge if the FIFO is not full.
  - If the FIFO is full, the flit is dropped and i_ovf[k] sets, clearing only on reset.
  - A write and a read in the same cycle on a full FIFO: the write is still dropped; full is evaluated before the edge.
  - A write and a read on an empty FIFO is impossible, because reads need a stored flit.
- Request: FIFO k non-empty with a head at its front requests output dest(k). Body/tail at the front follow input k's locked output.
- Arbitration, per output j, combinational, only while j is unlocked:
  - Candidates are inputs whose front flit is a head destined to j.
  - Search starts at ptr_j+1 and wraps modulo N.
  - On a head transfer: lock j to the winner, set ptr_j = winner.
  - While locked, only the owner may send to j.
- Transfer to output j occurs when j is owned or just granted, owner FIFO non-empty, and (o_flit[j] is idle or o_ready[j]=1):
  - The front flit is popped and registered into o_flit[j].
  - If the owner FIFO is empty, the lock is held and no flit is sent (bubble).
- Output register:
  - o_flit[j] holds its flit until o_ready[j]=1.
  - If consumed with no new transfer, it returns to 0 at the next edge.
- Lock release:
  - Transferring a tail clears the lock on j at that edge.
  - A new head may be granted to j at the next cycle at earliest, giving a 1-cycle bubble between packets on one output.
- Latency: flit presented at cycle t into an empty FIFO with free output and ready=1 appears on o_flit at cycle t+2. Sustained throughput is 1 flit/cycle/output within a packet.
- Multiple outputs operate independently and concurrently. An input has only one FIFO front, so at most one transfer per input per cycle.
- A head to a non-existent port (dest >= N, only possible when N is not a power of two) is routed to dest mod N.
- Body or tail at a FIFO front with no lock held (malformed stream) is popped and discarded next cycle, producing no output.
- Reset mid-packet discards all buffered flits and locks immediately; o_flit=0 asynchronously.

Test Plan:
- Single packet, N=4 W=10: i0 sends 0x102 (head, dest 2), 0x2AA, 0x355 on cycles 1-3, o_ready=all 1 -> o_flit[2] shows 0x102, 0x2AA, 0x355 on cycles 3-5; other outputs 0; i_full=0.
- Contention: i0 and i1 both send head to dest 1 (0x101) plus body and tail in the same cycle -> i0 packet first and wholly uninterrupted; 1 idle cycle; then i1 packet; ptr_1=1 afterward.
- Round-robin fairness: i0..i3 continuously send 2-flit packets to dest 0 -> grant order 0,1,2,3,0; no input is granted twice before every other requester is granted once.
- Backpressure and overflow: o_ready[3]=0, i2 sends head 0x103 then 5 bodies -> o_flit[3] holds 0x103, FIFO fills; i_full[2]=1 after the 4th stored flit; the 6th flit (5th body) is dropped and i_ovf[2]=1. Raising o_ready resumes in order with no duplication.
- Parallel paths: i0->dest 3 and i3->dest 0 simultaneously -> both outputs carry their packets in the same cycles with no interference.
- Reset mid-packet: assert rst low during the body of a packet -> o_flit=0 immediately. After release, a new head from any input is granted normally and the stale tail never appears.
